// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: load-type encodings and the zero register index.
package mips_defs;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic is_half_load(logic [2:0] lt);
    return (lt == LT_LH) || (lt == LT_LHU);
  endfunction

  function automatic logic is_byte_load(logic [2:0] lt);
    return (lt == LT_LB) || (lt == LT_LBU);
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// MEM/WB boundary bundle: memory-stage results and hazard controls in, write-back results out.
interface writeback_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              RegWriteM;
  logic              MemToRegM;
  logic [2:0]        LoadTypeM;
  logic              ValidM;
  logic [DATA_W-1:0] ALUOutM;
  logic [DATA_W-1:0] ReadDataM;
  logic [REG_AW-1:0] WriteRegM;
  logic              StallW;
  logic              FlushW;

  logic              RegWriteW;
  logic [REG_AW-1:0] WriteRegW;
  logic [DATA_W-1:0] ResultW;
  logic [DATA_W-1:0] ALUOutW;
  logic              ValidW;
  logic              MisalignW;
  logic [31:0]       RetireCount;

  modport master (
    output RegWriteM, MemToRegM, LoadTypeM, ValidM, ALUOutM, ReadDataM, WriteRegM,
           StallW, FlushW,
    input  RegWriteW, WriteRegW, ResultW, ALUOutW, ValidW, MisalignW, RetireCount
  );

  modport slave (
    input  RegWriteM, MemToRegM, LoadTypeM, ValidM, ALUOutM, ReadDataM, WriteRegM,
           StallW, FlushW,
    output RegWriteW, WriteRegW, ResultW, ALUOutW, ValidW, MisalignW, RetireCount
  );
endinterface

// File: rtl/writeback_stage_load_extract.sv
// Big-endian sub-word load extraction with sign/zero extension and alignment check.
module load_extract
  import mips_defs::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    unique case (addr_i)
      2'd0: byte_sel = word_i[31:24];
      2'd1: byte_sel = word_i[23:16];
      2'd2: byte_sel = word_i[15:8];
      2'd3: byte_sel = word_i[7:0];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_i[1] ? word_i[15:0] : word_i[31:16];

    // Unknown encodings 5-7 fall through as a full-word load.
    data_o     = word_i;
    misalign_o = (addr_i != 2'd0);
    case (load_type_i)
      LT_LH: begin
        data_o     = {{16{half_sel[15]}}, half_sel};
        misalign_o = addr_i[0];
      end
      LT_LHU: begin
        data_o     = {16'h0000, half_sel};
        misalign_o = addr_i[0];
      end
      LT_LB: begin
        data_o     = {{24{byte_sel[7]}}, byte_sel};
        misalign_o = 1'b0;
      end
      LT_LBU: begin
        data_o     = {24'h000000, byte_sel};
        misalign_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back select with stall/flush, misalign flag and retire count.
module writeback_stage
  import mips_defs::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic               clk,
  input logic               rst_n,
  writeback_stage_if.slave  wb
);

  logic              reg_write_q;
  logic              mem_to_reg_q;
  logic [2:0]        load_type_q;
  logic              valid_q;
  logic [DATA_W-1:0] alu_out_q;
  logic [DATA_W-1:0] read_data_q;
  logic [REG_AW-1:0] write_reg_q;
  logic [31:0]       retire_count_q;

  logic [31:0] load_data;
  logic        load_misalign;
  logic        misalign;

  // Flush beats stall; a bubble never carries a register write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      load_type_q  <= LT_LW;
      valid_q      <= 1'b0;
      alu_out_q    <= '0;
      read_data_q  <= '0;
      write_reg_q  <= '0;
    end else if (wb.FlushW) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      load_type_q  <= LT_LW;
      valid_q      <= 1'b0;
      alu_out_q    <= '0;
      read_data_q  <= '0;
      write_reg_q  <= '0;
    end else if (!wb.StallW) begin
      reg_write_q  <= wb.RegWriteM & wb.ValidM;
      mem_to_reg_q <= wb.MemToRegM;
      load_type_q  <= wb.LoadTypeM;
      valid_q      <= wb.ValidM;
      alu_out_q    <= wb.ALUOutM;
      read_data_q  <= wb.ReadDataM;
      write_reg_q  <= wb.WriteRegM;
    end
  end

  // An instruction retires when it leaves W unstalled and unflushed, misaligned or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count_q <= '0;
    end else if (valid_q && !wb.StallW && !wb.FlushW) begin
      retire_count_q <= retire_count_q + 32'd1;
    end
  end

  load_extract u_load_extract (
    .word_i      (read_data_q[31:0]),
    .addr_i      (alu_out_q[1:0]),
    .load_type_i (load_type_q),
    .data_o      (load_data),
    .misalign_o  (load_misalign)
  );

  always_comb begin
    misalign       = valid_q & mem_to_reg_q & load_misalign;
    wb.MisalignW   = misalign;
    wb.ValidW      = valid_q;
    wb.WriteRegW   = write_reg_q;
    wb.ALUOutW     = alu_out_q;
    wb.ResultW     = mem_to_reg_q ? load_data : alu_out_q;
    wb.RegWriteW   = reg_write_q & valid_q & ~misalign & (write_reg_q != REG_ZERO);
    wb.RetireCount = retire_count_q;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed bench for writeback_stage against a per-instruction reference model.
module tb_writeback_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  writeback_stage_if #(.DATA_W(32), .REG_AW(5)) wb ();

  writeback_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in W, plus the retire tally.
  typedef struct {
    bit          valid;
    bit          rw;
    bit          m2r;
    bit [2:0]    lt;
    bit [31:0]   alu;
    bit [31:0]   rd;
    bit [4:0]    wr;
  } winst_t;

  winst_t    m_w;
  bit [31:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] m_load(input winst_t w);
    int unsigned a;
    bit [31:0]   b;
    bit [31:0]   h;
    a = int'(w.alu[1:0]);
    b = (w.rd >> (8 * (3 - a))) & 32'hFF;
    h = (a >= 2) ? (w.rd & 32'hFFFF) : (w.rd >> 16);
    case (w.lt)
      3'd1: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd2: return h;
      3'd3: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4: return b;
      default: return w.rd;
    endcase
  endfunction

  function automatic bit m_mis(input winst_t w);
    bit half;
    bit word;
    half = (w.lt == 3'd1) || (w.lt == 3'd2);
    word = (w.lt == 3'd0) || (w.lt >= 3'd5);
    return w.valid && w.m2r && ((half && (w.alu % 2 == 1)) || (word && (w.alu % 4 != 0)));
  endfunction

  task automatic check_outputs();
    bit mis;
    mis = m_mis(m_w);
    check("valid", {31'b0, wb.ValidW}, {31'b0, m_w.valid});
    check("misalign", {31'b0, wb.MisalignW}, {31'b0, mis});
    check("regwrite", {31'b0, wb.RegWriteW},
          {31'b0, m_w.rw && m_w.valid && !mis && (m_w.wr != 0)});
    check("writereg", {27'b0, wb.WriteRegW}, {27'b0, m_w.wr});
    check("aluout", wb.ALUOutW, m_w.alu);
    check("result", wb.ResultW, m_w.m2r ? m_load(m_w) : m_w.alu);
    check("retire", wb.RetireCount, m_cnt);
  endtask

  task automatic model_reset();
    m_w   = '{default: '0};
    m_cnt = 0;
  endtask

  task automatic cycle(input bit rw, input bit m2r, input bit [2:0] lt, input bit v,
                       input bit [31:0] alu, input bit [31:0] rd, input bit [4:0] wr,
                       input bit st, input bit fl);
    wb.RegWriteM = rw;
    wb.MemToRegM = m2r;
    wb.LoadTypeM = lt;
    wb.ValidM    = v;
    wb.ALUOutM   = alu;
    wb.ReadDataM = rd;
    wb.WriteRegM = wr;
    wb.StallW    = st;
    wb.FlushW    = fl;
    @(posedge clk);
    if (m_w.valid && !st && !fl) m_cnt = m_cnt + 1;
    if (fl) begin
      m_w = '{default: '0};
    end else if (!st) begin
      m_w = '{valid: v, rw: rw && v, m2r: m2r, lt: lt, alu: alu, rd: rd, wr: wr};
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
  endtask

  task automatic async_reset_check();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", {31'b0, wb.ValidW}, 32'h0);
    check("arst_regwrite", {31'b0, wb.RegWriteW}, 32'h0);
    check("arst_misalign", {31'b0, wb.MisalignW}, 32'h0);
    check("arst_writereg", {27'b0, wb.WriteRegW}, 32'h0);
    check("arst_result", wb.ResultW, 32'h0);
    check("arst_aluout", wb.ALUOutW, 32'h0);
    check("arst_retire", wb.RetireCount, 32'h0);
    #1 rst_n = 1'b1;
  endtask

  localparam bit [31:0] RD = 32'h80FF_7F01;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst_n        = 1'b0;
    wb.RegWriteM = 0;
    wb.MemToRegM = 0;
    wb.LoadTypeM = 0;
    wb.ValidM    = 0;
    wb.ALUOutM   = 0;
    wb.ReadDataM = 0;
    wb.WriteRegM = 0;
    wb.StallW    = 0;
    wb.FlushW    = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Basic ALU write-back, then retire one cycle later.
    cycle(1, 0, 0, 1, 32'h0000_1234, 32'h0, 5'd8, 0, 0);
    check("first_result", wb.ResultW, 32'h0000_1234);
    check("first_regwrite", {31'b0, wb.RegWriteW}, 32'h1);
    idle();
    check("first_retire", wb.RetireCount, 32'd1);

    // Sub-word loads from a fixed word.
    cycle(1, 1, 3'd3, 1, 32'h100, RD, 5'd9, 0, 0);
    check("lb", wb.ResultW, 32'hFFFF_FF80);
    cycle(1, 1, 3'd4, 1, 32'h101, RD, 5'd9, 0, 0);
    check("lbu", wb.ResultW, 32'h0000_00FF);
    cycle(1, 1, 3'd1, 1, 32'h102, RD, 5'd9, 0, 0);
    check("lh", wb.ResultW, 32'h0000_7F01);
    cycle(1, 1, 3'd2, 1, 32'h100, RD, 5'd9, 0, 0);
    check("lhu", wb.ResultW, 32'h0000_80FF);
    cycle(1, 1, 3'd0, 1, 32'h104, RD, 5'd9, 0, 0);
    check("lw", wb.ResultW, 32'h80FF_7F01);

    // Misaligned loads and writes to $0 are suppressed but still retire.
    cycle(1, 1, 3'd1, 1, 32'h103, RD, 5'd9, 0, 0);
    check("lh_mis", {31'b0, wb.MisalignW}, 32'h1);
    check("lh_mis_rw", {31'b0, wb.RegWriteW}, 32'h0);
    cycle(1, 1, 3'd0, 1, 32'h102, RD, 5'd9, 0, 0);
    check("lw_mis", {31'b0, wb.MisalignW}, 32'h1);
    cycle(1, 0, 3'd0, 1, 32'h55, RD, 5'd0, 0, 0);
    check("r0_rw", {31'b0, wb.RegWriteW}, 32'h0);
    idle();
    check("mis_retire", wb.RetireCount, 32'd9);

    // Stall freezes everything; flush with stall discards without counting.
    cycle(1, 0, 0, 1, 32'hABCD, 32'h0, 5'd3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 3'd1, 1, $urandom, $urandom, 5'(i + 4), 1, 0);
      check("stall_hold", wb.ALUOutW, 32'hABCD);
    end
    cycle(1, 0, 0, 1, 32'h77, 32'h0, 5'd5, 1, 1);
    check("flush_valid", {31'b0, wb.ValidW}, 32'h0);
    check("flush_count", wb.RetireCount, 32'd9);

    // Bubble with RegWrite asserted.
    cycle(1, 0, 0, 0, 32'h99, 32'h0, 5'd6, 0, 0);
    check("bubble_rw", {31'b0, wb.RegWriteW}, 32'h0);
    idle();

    // Counter wrap: preload near the top, then retire one instruction.
    cycle(1, 0, 0, 1, 32'h11, 32'h0, 5'd7, 0, 0);
    force dut.retire_count_q = 32'hFFFF_FFFF;
    #1 release dut.retire_count_q;
    m_cnt = 32'hFFFF_FFFF;
    check("preload", wb.RetireCount, 32'hFFFF_FFFF);
    idle();
    check("wrap", wb.RetireCount, 32'h0);

    // Asynchronous reset between edges, including while stalled.
    cycle(1, 1, 3'd3, 1, 32'h200, RD, 5'd10, 0, 0);
    async_reset_check();
    cycle(1, 0, 0, 1, 32'h300, 32'h0, 5'd11, 0, 0);
    cycle(1, 0, 0, 1, 32'h304, 32'h0, 5'd12, 1, 0);
    async_reset_check();
    idle();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            $urandom_range(0, 7) != 0, $urandom, $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
MEM/WB pipeline register plus write-back stage of the 5-stage MIPS core, directly downstream of the memory stage. Captures the memory stage's control, ALU result, read data and destination register each cycle. Performs sub-word load extraction (byte/half, signed/unsigned, big-endian) and selects the register-file write value. Handles stall/flush, flags misaligned loads, and keeps a retired-instruction counter.

Parameters:
DATA_W, 32, datapath width (only 32 supported)
REG_AW, 5, register index width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
RegWriteM  in  1  register-write enable from memory stage
MemToRegM  in  1  1 = result comes from data memory
LoadTypeM  in  3  load kind: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5-7 treated as LW
ValidM  in  1  memory stage holds a real instruction (0 = bubble)
ALUOutM  in  32  ALU result / effective address
ReadDataM  in  32  data memory read word (RD)
WriteRegM  in  5  destination register
StallW  in  1  hold W-stage contents
FlushW  in  1  insert bubble into W stage
RegWriteW  out  1  register-file write enable (qualified)
WriteRegW  out  5  register-file write address
ResultW  out  32  register-file write data
ALUOutW  out  32  registered ALU result, for hazard forwarding
ValidW  out  1  W stage holds a real instruction
MisalignW  out  1  W-stage instruction is a misaligned load
RetireCount  out  32  instructions retired since reset

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline registers, ValidW, RegWriteW, MisalignW and RetireCount cleared to 0. WriteRegW = 0 and ResultW = 0.
- Latency: one cycle. Values presented at edge N appear on outputs after edge N.
- Priority per edge: FlushW > StallW > normal capture.
  - FlushW=1: ValidW and the registered RegWrite go to 0. Other fields are don't-care but cleared to 0.
  - StallW=1 (no flush): every register holds.
  - Otherwise: capture all M inputs. A captured RegWrite is ANDed with ValidM.
- Extraction is combinational from the registered ReadData, ALUOut[1:0] and LoadType. Big-endian byte lanes: addr[1:0]=0 selects bits 31:24, 3 selects 7:0.
  - LB/LBU: selected byte, sign- or zero-extended to 32.
  - LH/LHU: addr[1]=0 selects 31:16, addr[1]=1 selects 15:0, sign- or zero-extended.
  - LW: full word.
- ResultW = extracted load data when registered MemToReg=1, else ALUOutW.
- MisalignW = ValidW & MemToReg & ((LH/LHU & addr[0]) | (LW & addr[1:0]!=0)). LB/LBU are never misaligned.
- RegWriteW = registered RegWrite & ValidW & ~MisalignW & (WriteRegW != 0). Writes to $0 are suppressed.
- RetireCount increments by 1 on each edge where ValidW=1, StallW=0 and FlushW=0 (the instruction leaves W).
  - Misaligned instructions still count.
  - Wraps 0xFFFFFFFF -> 0 with no flag.
- FlushW and StallW together: flush wins. The current instruction is discarded and not counted.
- Reset mid-stall or mid-flush: reset dominates immediately, no pending state survives.

Decomposition:
- Shared package/include mips_defs: LoadType encodings LT_LW=0, LT_LH=1, LT_LHU=2, LT_LB=3, LT_LBU=4, and the REG_ZERO=5'd0 constant. Memory and decode stages reuse these.
- One sub-module, load_extract: combinational, inputs word, addr[1:0] and load type; outputs the 32-bit extended data and a misalign bit.
- The pipeline registers, priority logic and counter stay in writeback_stage.

Test Plan:
- Reset then release:
  - RegWriteM=1, ValidM=1, MemToRegM=0, ALUOutM=0x0000_1234, WriteRegM=8.
  - Next cycle: RegWriteW=1, WriteRegW=8, ResultW=0x0000_1234, ValidW=1.
  - RetireCount reads 1 one cycle later.
- Loads with ReadDataM=0x80FF_7F01 and MemToRegM=1:
  - LB addr 0x100 -> 0xFFFF_FF80
  - LBU addr 0x101 -> 0x0000_00FF
  - LH addr 0x102 -> 0x0000_7F01
  - LHU addr 0x100 -> 0x0000_80FF
  - LW addr 0x104 -> 0x80FF_7F01
- Misaligned and $0 cases:
  - LH at addr 0x103 -> MisalignW=1, RegWriteW=0.
  - LW at 0x102 -> MisalignW=1.
  - WriteRegM=0 with RegWriteM=1 -> RegWriteW=0.
  - Each of these still increments RetireCount.
- Stall and flush:
  - StallW=1 for 3 cycles with changing M inputs -> outputs frozen, RetireCount unchanged.
  - FlushW=1 with StallW=1 -> ValidW=0, RegWriteW=0 next cycle, count unchanged.
- Bubble: ValidM=0 with RegWriteM=1 -> RegWriteW=0, ValidW=0, no count.
- Counter wrap and async reset:
  - Force RetireCount to 0xFFFF_FFFF via a retire stream -> next retire gives 0.
  - Assert rst_n low between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
